uart_rx: RTL and testbench

Receive side of the FTDI serial link: samples the asynchronous `ftdi_rxd` line, recovers 8N1 frames (8E1 with parity enabled) at a fixed baud set by a cycle divisor, and presents each byte through a one-entry valid/ready holding register. Sits beside the transmitter on the 25 MHz clock domain and feeds host-command parsing logic; also mirrors the last received byte on `led`.

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 framing (even parity bit between data and stop).
module uart_rx #(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic       clk_25mhz,
    input  logic       reset_n,
    input  logic       ftdi_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_overrun,
    output logic [7:0] led
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rxd_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          mid, tick, stop_tick, par_bad;
    logic [7:0]    rx_data_q, rx_data_d;
    logic [7:0]    led_q, led_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
    logic          par_err_q, par_err_d;
    logic          parity_err_q, parity_err_d;
    assign par_bad       = par_err_q;
    assign rx_parity_err = parity_err_q;
`else
    assign par_bad       = 1'b0;
    assign rx_parity_err = 1'b0;
`endif

    assign rxd_s     = sync_q[1];
    assign mid       = cnt_q == MID;
    assign tick      = cnt_q == LAST;
    assign stop_tick = state_q == STOP && tick;

    // Two-flop synchronizer; resets to idle-high so reset never looks like a start edge
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], ftdi_rxd};
    end

    // Frame-tracking state: FSM state, baud counter, bit index, shift register
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // Next state; counter restarts on every state entry so each state times from its own start
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE:  state_d = rxd_s ? IDLE : START;
            START: begin
                if (mid) begin
                    state_d = rxd_s ? IDLE : DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    state_d = (bit_q == 3'd7) ? PARITY : DATA;
`else
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_err_d = rxd_s ^ (^shift_q);
                    state_d   = STOP;
                end
            end
`endif
            STOP:    state_d = tick ? (rxd_s ? IDLE : BREAK) : STOP;
            BREAK:   state_d = rxd_s ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_q == IDLE || state_d != state_q || tick) ? '0 : cnt_q + CW'(1);
    end

    // Commit logic: frame error beats parity beats overrun, one flag per failed frame
    always_comb begin
        rx_valid_d   = rx_valid_q && !rx_ready;
        rx_data_d    = rx_data_q;
        led_d        = led_q;
        frame_err_d  = stop_tick && !rxd_s;
        overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = stop_tick && rxd_s && par_bad;
`endif
        if (stop_tick && rxd_s && !par_bad) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                led_d      = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end
    end

    // Holding register and registered status pulses
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q    <= '0;
            led_q        <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_data_q    <= rx_data_d;
            led_q        <= led_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data      = rx_data_q;
    assign led          = led_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ftdi_rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_overrun;
    logic [7:0] led;

    int n_cmp = 0;
    int n_bad = 0;
    int n_vcyc, n_ferr, n_perr, n_ovr;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_25mhz    (clk),
        .reset_n      (reset_n),
        .ftdi_rxd     (ftdi_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_overrun   (rx_overrun),
        .led          (led)
    );

    // Observe outputs mid-cycle; inputs only change just after the rising edge
    always @(negedge clk) begin
        if (rx_valid) n_vcyc++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_frame_err) n_ferr++;
        if (rx_parity_err) n_perr++;
        if (rx_overrun) n_ovr++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear();
        n_vcyc = 0;
        n_ferr = 0;
        n_perr = 0;
        n_ovr  = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        ftdi_rxd = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            ftdi_rxd = d[i];
            step(CPB);
        end
`ifdef UART_RX_PARITY_EN
        ftdi_rxd = ($countones(d) % 2) == 1;
        step(CPB);
`endif
        ftdi_rxd = stop;
        step(CPB);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        ftdi_rxd = 1'b1;
        rx_ready = 1'b0;
        step(3);
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL reset_led: got %h expected 00", led); end
        n_cmp++; if ({rx_frame_err, rx_parity_err, rx_overrun} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b expected 000", {rx_frame_err, rx_parity_err, rx_overrun}); end
        reset_n = 1'b1;
        step(5);
    endtask

    task automatic test_basic();
        clear();
        rx_ready = 1'b1;
        send(8'hA5, 1'b1);
        step(4);
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %0d bytes first %h expected 1 byte a5", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx); end
        n_cmp++; if (led !== 8'hA5) begin n_bad++; $display("FAIL basic_led: got %h expected a5", led); end
        n_cmp++; if (n_vcyc != 1) begin n_bad++; $display("FAIL basic_valid_cycles: got %0d expected 1", n_vcyc); end
        n_cmp++; if (n_ferr + n_perr + n_ovr != 0) begin n_bad++; $display("FAIL basic_errors: got %0d expected 0", n_ferr + n_perr + n_ovr); end
    endtask

    task automatic test_overrun();
        clear();
        rx_ready = 1'b0;
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b1);
        step(4);
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL ovr_data_kept: got %h expected 3c", rx_data); end
        n_cmp++; if (led !== 8'h3C) begin n_bad++; $display("FAIL ovr_led: got %h expected 3c", led); end
        n_cmp++; if (n_ovr != 1 || n_ferr != 0) begin n_bad++; $display("FAIL ovr_pulse: got ovr %0d ferr %0d expected 1 0", n_ovr, n_ferr); end
        rx_ready = 1'b1;
        step(1);
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_valid_drop: got %b expected 0", rx_valid); end
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin n_bad++; $display("FAIL ovr_accept: got %0d bytes expected 1 byte 3c", got_q.size()); end
    endtask

    task automatic test_frame();
        clear();
        rx_ready = 1'b1;
        send(8'h55, 1'b0);
        step(200);
        n_cmp++; if (n_ferr != 1) begin n_bad++; $display("FAIL frame_pulse: got %0d expected 1", n_ferr); end
        n_cmp++; if (n_vcyc != 0 || n_perr != 0 || n_ovr != 0) begin n_bad++; $display("FAIL frame_no_valid: got vcyc %0d perr %0d ovr %0d expected 0 0 0", n_vcyc, n_perr, n_ovr); end
        ftdi_rxd = 1'b1;
        step(20);
        send(8'h5A, 1'b1);
        step(4);
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h5A || n_ferr != 1) begin n_bad++; $display("FAIL frame_recover: got %0d bytes ferr %0d expected 1 byte 5a ferr 1", got_q.size(), n_ferr); end
    endtask

    task automatic test_glitch();
        clear();
        ftdi_rxd = 1'b0;
        step(4);
        ftdi_rxd = 1'b1;
        step(30);
        n_cmp++; if (n_vcyc + n_ferr + n_perr + n_ovr != 0) begin n_bad++; $display("FAIL glitch_quiet: got %0d events expected 0", n_vcyc + n_ferr + n_perr + n_ovr); end
        n_cmp++; if (led !== 8'h5A) begin n_bad++; $display("FAIL glitch_led: got %h expected 5a", led); end
        send(8'h01, 1'b1);
        step(4);
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h01) begin n_bad++; $display("FAIL glitch_next: got %0d bytes expected 1 byte 01", got_q.size()); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear();
        send(8'h07, 1'b1);
        step(4);
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h07 || n_perr != 0) begin n_bad++; $display("FAIL parity_good: got %0d bytes perr %0d expected 1 byte 07 perr 0", got_q.size(), n_perr); end
        ftdi_rxd = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            ftdi_rxd = i < 3;
            step(CPB);
        end
        ftdi_rxd = 1'b0;
        step(CPB);
        ftdi_rxd = 1'b1;
        step(CPB + 4);
        n_cmp++; if (n_perr != 1 || got_q.size() != 1 || n_ovr != 0 || n_ferr != 0) begin n_bad++; $display("FAIL parity_bad: got perr %0d bytes %0d expected perr 1 bytes 1", n_perr, got_q.size()); end
    endtask
`endif

    task automatic test_reset_mid();
        clear();
        rx_ready = 1'b1;
        ftdi_rxd = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            ftdi_rxd = 1'b1;
            step(CPB);
        end
        step(CPB / 2);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (led !== 8'h00 || rx_data !== 8'h00 || rx_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out: got led %h data %h valid %b expected 00 00 0", led, rx_data, rx_valid); end
        step(3);
        reset_n = 1'b1;
        step(2 * CPB);
        send(8'h81, 1'b1);
        step(4);
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h81 || n_ferr != 0) begin n_bad++; $display("FAIL midreset_next: got %0d bytes ferr %0d expected 1 byte 81 ferr 0", got_q.size(), n_ferr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        clear();
        rx_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            send(d, 1'b1);
            step($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 20));
        end
        step(4);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL b2b_byte%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
        end
        n_cmp++; if (n_ferr + n_perr + n_ovr != 0) begin n_bad++; $display("FAIL b2b_errors: got %0d expected 0", n_ferr + n_perr + n_ovr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame();
        test_glitch();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
